// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART byte receiver slice.
// Holds the receiver state encoding, default timing/FIFO sizes and the data width.
package uart_pkg;

  localparam int DATA_W               = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 86;
  localparam int DEFAULT_FIFO_DEPTH   = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } uart_state_t;

  // Even parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous byte FIFO with wrapping pointers (one extra MSB
// distinguishes full from empty). Head data reads 0 while empty.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [ADDR_W:0]  wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop_ok, push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 serial byte receiver with framing checks and an output byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with even-parity checking.
module uart_byte_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam int                 TIMER_W   = $clog2(CLKS_PER_BIT);
  localparam logic [TIMER_W-1:0] HALF_LOAD = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TIMER_W-1:0] BIT_LOAD  = TIMER_W'(CLKS_PER_BIT - 1);

  logic              rx_meta, rx_s;
  logic [1:0]        sync_fill;
  uart_state_t       state, state_next;
  logic [TIMER_W-1:0] timer;
  logic              timer_zero;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shift;
  logic              armed;
  logic              push_req, frame_err_set, overrun_set, pop;
  logic              fifo_full, fifo_empty;

  // NOTE: non-blocking assignments keep these as two real flop stages; blocking
  // ones would let rx fall straight through to rx_s in a single clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      sync_fill <= 2'b00;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  assign timer_zero = (timer == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: default assignment first so every path drives state_next and no latch forms.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (armed && !rx_s) state_next = START;
      START:      if (timer_zero) state_next = rx_s ? IDLE : DATA;
      DATA: begin
        if (timer_zero && bit_idx == 3'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY:     if (timer_zero) state_next = STOP;
`endif
      STOP:       if (timer_zero) state_next = rx_s ? IDLE : BREAK_WAIT;
      BREAK_WAIT: if (rx_s) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic parity_err_set;
`endif

  always_comb begin
    push_req      = 1'b0;
    frame_err_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_set = 1'b0;
`endif
    if (state == STOP && timer_zero) begin
      if (!rx_s) frame_err_set = 1'b1;
`ifdef UART_RX_PARITY_EN
      else if (par_bad) parity_err_set = 1'b1;
`endif
      else push_req = 1'b1;
    end
  end

  // Bit timing: IDLE preloads the half-bit delay so START lands mid start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      armed   <= 1'b0;
    end else begin
      if (state == IDLE)
        timer <= HALF_LOAD;
      else if (timer_zero && (state == START || state == DATA || state == PARITY))
        timer <= BIT_LOAD;
      else if (!timer_zero)
        timer <= timer - 1'b1;

      if (state == START)
        bit_idx <= '0;
      else if (state == DATA && timer_zero)
        bit_idx <= bit_idx + 1'b1;

      if (state == DATA && timer_zero)
        shift <= {rx_s, shift[DATA_W-1:1]};

      // Reset values in the synchronizer are not line evidence, so arming
      // waits until both stages hold genuinely sampled data.
      if (state != IDLE)
        armed <= 1'b0;
      else if (rx_s && sync_fill[1])
        armed <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      par_bad <= 1'b0;
    else if (state == PARITY && timer_zero)
      par_bad <= (rx_s != even_parity(shift));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= parity_err_set;
  end
`else
  assign parity_err = 1'b0;
`endif

  assign pop         = out_ready;
  assign out_valid   = !fifo_empty;
  assign overrun_set = push_req && fifo_full && !(out_valid && out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_err_set;
      overrun   <= overrun_set;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (shift),
    .pop       (pop),
    .head_data (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Self-checking bench for uart_byte_receiver: directed frames plus randomized
// traffic, compared against a byte-queue model of the receiver's behaviour.
module tb_uart_byte_receiver;
  import uart_pkg::*;

  localparam int CPB   = DEFAULT_CLKS_PER_BIT;
  localparam int DEPTH = DEFAULT_FIFO_DEPTH;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid, frame_err, overrun, parity_err;

  uart_byte_receiver #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #50 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: bytes the receiver should deliver, in order, plus event tallies.
  logic [7:0] exp_q[$];
  int exp_fe = 0, exp_pe = 0, exp_ov = 0, exp_pops = 0;
  int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, pops = 0;
  int rise_cyc = 0, run = 0, last_run = 0, fall_cyc = 0;
  logic rand_ready = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : monitor
    logic prev_valid, prev_fe, prev_pe, prev_ov;
    prev_valid = 0; prev_fe = 0; prev_pe = 0; prev_ov = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 0; prev_fe = 0; prev_pe = 0; prev_ov = 0; run = 0;
      end else begin
        if (frame_err)  begin fe_cnt++; check("frame_err_width", prev_fe, 0); end
        if (parity_err) begin pe_cnt++; check("parity_err_width", prev_pe, 0); end
        if (overrun)    begin ov_cnt++; check("overrun_width", prev_ov, 0); end
        if (out_valid && !prev_valid) rise_cyc = cyc;
        if (out_valid) run++;
        else if (prev_valid) begin last_run = run; run = 0; end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("pop_unexpected", exp_q.size(), 1);
          else begin
            check("pop_data", out_data, exp_q.pop_front());
            pops++;
          end
        end
        prev_valid = out_valid; prev_fe = frame_err; prev_pe = parity_err; prev_ov = overrun;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Called at posedge+1; holds rx at v for n clocks and returns at posedge+1.
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input int stop_low);
    if (stop_low > 0) exp_fe++;
    else if (par_flip) exp_pe++;
    else if (exp_q.size() >= DEPTH && !out_ready) exp_ov++;
    else begin exp_q.push_back(d); exp_pops++; end
    fall_cyc = cyc;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    hold((^d) ^ par_flip, CPB);
`endif
    if (stop_low > 0) hold(1'b0, stop_low * CPB);
    hold(1'b1, CPB);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_fe"}, frame_err, 0);
    check({tag, "_ov"}, overrun, 0);
    check({tag, "_pe"}, parity_err, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int pops_before;
    rst = 1'b1; rx = 1'b1; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    hold(1'b1, 2 * CPB);

    // Single byte and its latency from the rx falling edge.
    send_frame(8'hA5, 1'b0, 0);
    check("a5_latency", rise_cyc - fall_cyc, 2 + CPB / 2 + 9 * CPB + 1
`ifdef UART_RX_PARITY_EN
          + CPB
`endif
          );
    check("a5_valid_cycles", last_run, 1);
    check("a5_pops", pops, exp_pops);

    // Short low glitch must not start a frame.
    hold(1'b0, 20);
    hold(1'b1, 1000);
    check("glitch_pops", pops, exp_pops);
    check("glitch_fe", fe_cnt, exp_fe);
    check("glitch_ov", ov_cnt, exp_ov);

    // Framing error, then a clean byte.
    send_frame(8'h3C, 1'b0, 2);
    hold(1'b1, 2 * CPB);
    check("ferr_count", fe_cnt, exp_fe);
    send_frame(8'h55, 1'b0, 0);
    hold(1'b1, CPB);
    check("after_ferr_pops", pops, exp_pops);
    check("after_ferr_fe", fe_cnt, exp_fe);

    // Back-to-back frames into a stalled FIFO.
    out_ready = 1'b0;
    pops_before = pops;
    for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b0, 0);
    check("ov_before_fifth", ov_cnt, exp_ov);
    send_frame(8'h05, 1'b0, 0);
    hold(1'b1, CPB);
    check("ov_count", ov_cnt, exp_ov);
    check("stalled_valid", out_valid, 1);
    check("stalled_head", out_data, 8'h01);
    out_ready = 1'b1;
    hold(1'b1, 10);
    check("drained_pops", pops - pops_before, 4);
    check("drained_valid", out_valid, 0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h0F, 1'b0, 0);
    hold(1'b1, CPB);
    send_frame(8'h0F, 1'b1, 0);
    hold(1'b1, CPB);
    check("parity_err_count", pe_cnt, exp_pe);
    check("parity_pops", pops, exp_pops);
`endif

    // Reset during data bit 3 with rx low, line held low after release.
    hold(1'b0, CPB);
    hold(1'b0, 3 * CPB + CPB / 2);
    rst = 1'b1;
    hold(1'b0, 3);
    check_reset_values("midreset");
    rst = 1'b0;
    pops_before = pops;
    hold(1'b0, 200);
    hold(1'b1, 2 * CPB);
    send_frame(8'h7E, 1'b0, 0);
    hold(1'b1, CPB);
    check("midreset_pops", pops - pops_before, 1);
    check("midreset_fe", fe_cnt, exp_fe);

    // Randomized traffic with a randomly stalling consumer.
    rand_ready = 1'b1;
    for (int n = 0; n < 14; n++) begin
      logic [7:0] d;
      int         sl;
      logic       pf;
      d  = 8'($urandom);
      sl = ($urandom_range(0, 6) == 0) ? 1 : 0;
      pf = 1'b0;
`ifdef UART_RX_PARITY_EN
      pf = ($urandom_range(0, 5) == 0);
`endif
      send_frame(d, pf, sl);
      hold(1'b1, $urandom_range(CPB, 2 * CPB));
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain();

    check("final_pops", pops, exp_pops);
    check("final_fe", fe_cnt, exp_fe);
    check("final_pe", pe_cnt, exp_pe);
    check("final_ov", ov_cnt, exp_ov);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
